// File: rtl/mdu_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit.
// Holds the SPECIAL opcode, the eight MDU funct encodings, and the decoded
// operation type used between the decoder and the datapath.
package mdu_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MFHI,
    MD_MFLO,
    MD_MTHI,
    MD_MTLO
  } md_type_e;

  // True for the four operations that occupy the unit for several cycles.
  function automatic logic is_md_op(input md_type_e t);
    return (t == MD_MULT) || (t == MD_MULTU) || (t == MD_DIV) || (t == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_decode.sv
// Combinational decoder for MDU instructions.
// Ports:
//   op       in  6  opcode of the instruction in E
//   func     in  6  funct field of the instruction in E
//   exc_code in  5  nonzero when the instruction already faulted
//   md_type  out    decoded operation (MD_NONE for anything else)
module mdu_decode
  import mdu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [4:0] exc_code,
  output md_type_e   md_type
);

  // A faulted instruction must behave as a nop, so it never decodes.
  always_comb begin
    md_type = MD_NONE;
    if (op == OP_SPECIAL && exc_code == 5'd0) begin
      case (func)
        FUNCT_MULT:  md_type = MD_MULT;
        FUNCT_MULTU: md_type = MD_MULTU;
        FUNCT_DIV:   md_type = MD_DIV;
        FUNCT_DIVU:  md_type = MD_DIVU;
        FUNCT_MFHI:  md_type = MD_MFHI;
        FUNCT_MFLO:  md_type = MD_MFLO;
        FUNCT_MTHI:  md_type = MD_MTHI;
        FUNCT_MTLO:  md_type = MD_MTLO;
        default:     md_type = MD_NONE;
      endcase
    end
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with architectural HI/LO.
// The result of mult/multu/div/divu is computed at start and parked in
// temporary registers; it is committed to HI/LO when the cycle counter
// expires, so Busy models the latency seen by the hazard unit.
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-low reset
//   Req        in   1   flush: suppresses a new start or mthi/mtlo this cycle
//   E_op       in   6   opcode in E
//   E_func     in   6   funct in E
//   E_ExcCode  in   5   nonzero => instruction treated as nop
//   E_GPRrs    in   32  rs operand
//   E_GPRrt    in   32  rt operand
//   Start      out  1   an operation is accepted this cycle (combinational)
//   Busy       out  1   operation in flight (registered)
//   MDU_out    out  32  HI for mfhi, LO for mflo, else 0
//   HI, LO     out  32  committed HI/LO
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [5:0]  E_op,
  input  logic [5:0]  E_func,
  input  logic [4:0]  E_ExcCode,
  input  logic [31:0] E_GPRrs,
  input  logic [31:0] E_GPRrt,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] MDU_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_type_e md_type;

  logic             busy_q,   busy_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [31:0]      tmp_hi_q, tmp_hi_d;
  logic [31:0]      tmp_lo_q, tmp_lo_d;
  logic             commit_q, commit_d;
  logic [31:0]      hi_q,     hi_d;
  logic [31:0]      lo_q,     lo_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        rt_zero;
  logic        div_ovf;

  mdu_decode u_decode (
    .op       (E_op),
    .func     (E_func),
    .exc_code (E_ExcCode),
    .md_type  (md_type)
  );

  assign Start = is_md_op(md_type) && !Req && !busy_q;

  // Arithmetic on the live operands. Divide-by-zero and the signed
  // overflow case (0x80000000 / -1) are steered away from the divider so the
  // result is well defined; the overflow case yields quotient 0x80000000, rem 0.
  always_comb begin
    prod_s  = $signed({{32{E_GPRrs[31]}}, E_GPRrs}) * $signed({{32{E_GPRrt[31]}}, E_GPRrt});
    prod_u  = {32'b0, E_GPRrs} * {32'b0, E_GPRrt};
    rt_zero = (E_GPRrt == 32'd0);
    div_ovf = (E_GPRrs == 32'h8000_0000) && (E_GPRrt == 32'hFFFF_FFFF);
    quot_s  = 32'd0;
    rem_s   = 32'd0;
    quot_u  = 32'd0;
    rem_u   = 32'd0;
    if (div_ovf) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else if (!rt_zero) begin
      quot_s = $signed(E_GPRrs) / $signed(E_GPRrt);
      rem_s  = $signed(E_GPRrs) % $signed(E_GPRrt);
    end
    if (!rt_zero) begin
      quot_u = E_GPRrs / E_GPRrt;
      rem_u  = E_GPRrs % E_GPRrt;
    end
  end

  // Next-state logic. Start, the countdown and mthi/mtlo are mutually
  // exclusive because mthi/mtlo are only honoured while idle. A divide by
  // zero still runs the full latency but clears commit so HI/LO are kept.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (Start) begin
      busy_d   = 1'b1;
      commit_d = 1'b1;
      case (md_type)
        MD_MULT: begin
          {tmp_hi_d, tmp_lo_d} = prod_s;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        MD_MULTU: begin
          {tmp_hi_d, tmp_lo_d} = prod_u;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        MD_DIV: begin
          tmp_hi_d = rem_s;
          tmp_lo_d = quot_s;
          commit_d = !rt_zero;
          cnt_d    = CNT_W'(DIV_CYCLES);
        end
        default: begin
          tmp_hi_d = rem_u;
          tmp_lo_d = quot_u;
          commit_d = !rt_zero;
          cnt_d    = CNT_W'(DIV_CYCLES);
        end
      endcase
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (commit_q) begin
          hi_d = tmp_hi_q;
          lo_d = tmp_lo_q;
        end
      end
    end else if (!Req) begin
      if (md_type == MD_MTHI) hi_d = E_GPRrs;
      if (md_type == MD_MTLO) lo_d = E_GPRrs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      commit_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Reads always see the committed registers, even while an op is in flight.
  always_comb begin
    MDU_out = 32'd0;
    if (md_type == MD_MFHI) MDU_out = hi_q;
    if (md_type == MD_MFLO) MDU_out = lo_q;
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
